// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Shares the write port of one DATA_W-bit datapath register among
//            NUM_REQ requesters. Round-robin arbitration with a 4-phase
//            req/ack handshake per requester, plus a level-sensitive clear
//            request that takes priority over writes whenever the arbiter
//            is idle. Every output is a pure decode of registered state, so
//            there is no combinational path from any input to any output.
// Ports    :
//   clk        in   1               system clock, rising edge
//   clr        in   1               asynchronous active-low reset
//   req        in   NUM_REQ         write requests, level, one per requester
//   req_data   in   NUM_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
//   clr_req    in   1               request to clear the shared register, level
//   gnt        out  NUM_REQ         one-hot grant, high while writing
//   ack        out  NUM_REQ         one-hot ack, high until the winner drops req
//   clr_done   out  1               one-cycle pulse after the clear was issued
//   reg_d      out  DATA_W          data to the shared register input
//   reg_wr_en  out  1               shared register write enable
//   reg_clr    out  1               shared register clear, active-high, 1 cycle
//   busy       out  1               arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      clr_req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      clr_done,
  output logic [DATA_W-1:0]         reg_d,
  output logic                      reg_wr_en,
  output logic                      reg_clr,
  output logic                      busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  // Pointer resets to the last requester so that requester 0 is searched
  // first after reset.
  localparam logic [PTR_W-1:0] C_PTR_RST = PTR_W'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // State and captured registers
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,    state_d;
  logic [PTR_W-1:0]  ptr_q,      ptr_d;      // last winner, also current owner
  logic [DATA_W-1:0] data_q,     data_d;     // value presented on reg_d
  logic              clr_done_q, clr_done_d;

  // --------------------------------------------------------------------------
  // Unpack the flat request data bus into one word per requester
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // --------------------------------------------------------------------------
  // Round-robin winner search: first set request at ptr+1, ptr+2, ...
  // wrapping modulo NUM_REQ. The current pointer itself is examined last,
  // so a requester cannot win twice in a row while others are waiting.
  // --------------------------------------------------------------------------
  logic             any_req;
  logic [PTR_W-1:0] pick;

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_p;
    logic             found;
    any_req = |req;
    pick    = ptr_q;
    found   = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(ptr_q) + k) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      ptr_q      <= C_PTR_RST;
      data_q     <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      clr_done_q <= clr_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    // clr_done follows the single CLEAR cycle by exactly one cycle.
    clr_done_d = (state_q == S_CLEAR);

    unique case (state_q)
      S_IDLE: begin
        // Clear wins over any pending write; the pointer is left alone so
        // fairness is unaffected by clears.
        if (clr_req) begin
          state_d = S_CLEAR;
        end else if (any_req) begin
          state_d = S_WRITE;
          ptr_d   = pick;
          data_d  = req_word[pick];
        end
      end

      // Single write cycle; the register loads on the edge leaving WRITE.
      S_WRITE: state_d = S_ACK;

      // Hold the ack until the owner withdraws its request. Other requests
      // and clr_req are not looked at until the arbiter is idle again.
      S_ACK: begin
        if (!req[ptr_q]) begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore: state and captured registers only)
  // --------------------------------------------------------------------------
  always_comb begin
    gnt       = '0;
    ack       = '0;
    reg_wr_en = 1'b0;
    reg_clr   = 1'b0;
    busy      = (state_q != S_IDLE);
    reg_d     = data_q;
    clr_done  = clr_done_q;

    unique case (state_q)
      S_WRITE: begin
        gnt[ptr_q] = 1'b1;
        reg_wr_en  = 1'b1;
      end
      S_ACK: begin
        ack[ptr_q] = 1'b1;
      end
      S_CLEAR: begin
        reg_clr = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter. A transaction-level
//            model of the arbiter predicts every output each cycle; directed
//            scenarios pin specific values, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clr = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           clr_req = 1'b0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           clr_done;
  logic [W-1:0]   reg_d;
  logic           reg_wr_en;
  logic           reg_clr;
  logic           busy;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .req_data  (req_data),
    .clr_req   (clr_req),
    .gnt       (gnt),
    .ack       (ack),
    .clr_done  (clr_done),
    .reg_d     (reg_d),
    .reg_wr_en (reg_wr_en),
    .reg_clr   (reg_clr),
    .busy      (busy)
  );

  // The shared register the arbiter drives.
  logic [W-1:0] shreg = '0;
  always @(posedge clk) begin
    if (reg_clr)        shreg <= '0;
    else if (reg_wr_en) shreg <= reg_d;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] oh(input int idx);
    oh = 32'd1 << idx;
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural model: phase of the current transaction, its owner and data
  // --------------------------------------------------------------------------
  localparam int P_IDLE = 0;
  localparam int P_WR   = 1;
  localparam int P_ACK  = 2;
  localparam int P_CLR  = 3;

  int           m_ph   = P_IDLE;
  int           m_ptr  = N - 1;
  logic [W-1:0] m_data = '0;
  bit           m_done = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_ph   = P_IDLE;
      m_ptr  = N - 1;
      m_data = '0;
      m_done = 1'b0;
    end else begin
      bit nd;
      nd = (m_ph == P_CLR);
      case (m_ph)
        P_IDLE: begin
          if (clr_req) m_ph = P_CLR;
          else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
              int c;
              c = (m_ptr + k) % N;
              if (req[c]) begin
                m_ptr = c;
                break;
              end
            end
            m_data = req_data[m_ptr*W +: W];
            m_ph   = P_WR;
          end
        end
        P_WR:  m_ph = P_ACK;
        P_ACK: if (!req[m_ptr]) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
      m_done = nd;
    end
  end

  // Single compare process: every output, every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt",       32'(gnt),       (m_ph == P_WR)  ? oh(m_ptr) : 32'd0);
      chk("ack",       32'(ack),       (m_ph == P_ACK) ? oh(m_ptr) : 32'd0);
      chk("reg_wr_en", 32'(reg_wr_en), 32'(m_ph == P_WR));
      chk("reg_clr",   32'(reg_clr),   32'(m_ph == P_CLR));
      chk("busy",      32'(busy),      32'(m_ph != P_IDLE));
      chk("clr_done",  32'(clr_done),  32'(m_done));
      chk("reg_d",     reg_d,          m_data);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int gq[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // ---------------- Reset held with all requests high ----------------
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'(i + 1);
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_gnt",  32'(gnt),  32'd0);
    chk("rst_ack",  32'(ack),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_regd", reg_d,     32'd0);
    chk("rst_ctl",  32'({reg_wr_en, reg_clr, clr_done}), 32'd0);
    clr = 1'b1;
    step();
    chk("t1_gnt",  32'(gnt), 32'b0001);
    chk("t1_regd", reg_d,    32'd1);
    req = 4'b0001;
    step();
    chk("t1_ack", 32'(ack), 32'b0001);
    req = 4'b0000;
    step();
    chk("t1_busy",  32'(busy), 32'd0);
    chk("t1_shreg", shreg,     32'd1);

    // ---------------- Single write by requester 2 ----------------
    req_data[2*W +: W] = 32'hDEAD_BEEF;
    req = 4'b0100;
    step();
    chk("t2_gnt",  32'(gnt),       32'b0100);
    chk("t2_wr",   32'(reg_wr_en), 32'd1);
    chk("t2_regd", reg_d,          32'hDEAD_BEEF);
    step();
    chk("t2_ack",  32'(ack),       32'b0100);
    chk("t2_wr0",  32'(reg_wr_en), 32'd0);
    step();
    chk("t2_ackh", 32'(ack), 32'b0100);
    req = 4'b0000;
    step();
    chk("t2_busy",  32'(busy), 32'd0);
    chk("t2_shreg", shreg,     32'hDEAD_BEEF);

    // ---------------- Clear deferred during ACK of requester 3 ----------------
    req_data[3*W +: W] = 32'd56;
    req = 4'b1000;
    step();
    chk("t5_gnt", 32'(gnt), 32'b1000);
    step();
    chk("t5_ack", 32'(ack), 32'b1000);
    clr_req = 1'b1;
    step();
    chk("t5_noclr", 32'(reg_clr), 32'd0);
    chk("t5_ackh",  32'(ack),     32'b1000);
    req = 4'b0000;
    step();
    chk("t5_idle",  32'(busy),    32'd0);
    chk("t5_noclr2",32'(reg_clr), 32'd0);
    chk("t5_hold",  shreg,        32'd56);
    step();
    chk("t5_clr", 32'(reg_clr), 32'd1);
    clr_req = 1'b0;
    step();
    chk("t5_done",  32'(clr_done), 32'd1);
    chk("t5_zero",  shreg,         32'd0);

    // ---------------- Round robin with all requests held ----------------
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h100 + 32'(i);
    req = 4'b1111;
    for (int cyc = 0; cyc < 60 && gq.size() < 5; cyc++) begin
      step();
      if (gnt != '0) begin
        int g;
        g = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) g = i;
        gq.push_back(g);
      end
      req = ~ack;
    end
    chk("t3_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < gq.size() && i < 5; i++) chk("t3_order", 32'(gq[i]), 32'(exp_order[i]));
    req = 4'b0000;
    repeat (3) step();
    chk("t3_idle", 32'(busy), 32'd0);

    // ---------------- Clear and request together ----------------
    req_data[1*W +: W] = 32'd7;
    clr_req = 1'b1;
    req = 4'b0010;
    step();
    chk("t4_clr",  32'(reg_clr), 32'd1);
    chk("t4_ngnt", 32'(gnt),     32'd0);
    clr_req = 1'b0;
    step();
    chk("t4_done", 32'(clr_done), 32'd1);
    chk("t4_zero", shreg,         32'd0);
    step();
    chk("t4_gnt",  32'(gnt), 32'b0010);
    chk("t4_regd", reg_d,    32'd7);
    step();
    chk("t4_ack",   32'(ack), 32'b0010);
    chk("t4_seven", shreg,    32'd7);
    req = 4'b0000;
    step();
    chk("t4_idle", 32'(busy), 32'd0);

    // ---------------- Async reset while acking ----------------
    req_data[1*W +: W] = 32'd9;
    req = 4'b0010;
    step();
    step();
    chk("t6_ack", 32'(ack), 32'b0010);
    #2 clr = 1'b0;
    #1;
    chk("t6_ack0",  32'(ack),  32'd0);
    chk("t6_busy0", 32'(busy), 32'd0);
    chk("t6_gnt0",  32'(gnt),  32'd0);
    req = 4'b0000;
    step();
    step();
    clr = 1'b1;
    step();
    chk("t6_idle", 32'(busy), 32'd0);

    // ---------------- Randomized traffic ----------------
    for (int cyc = 0; cyc < 500; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        bit acked;
        acked = (m_ph == P_ACK) && (m_ptr == i);
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_data[i*W +: W] = $urandom;
          end
        end else if (acked) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      clr_req = ($urandom_range(0, 9) == 0);
    end
    req = '0;
    clr_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
